weight_mem_slave: RTL

WEIGHT_MEM_SLAVE -- requirements
Module: weight_mem_slave

---
 rtl/weight_mem_slave.sv | 129 ++++++++++++
 1 files changed

// File: rtl/weight_mem_slave.sv
// weight_mem_slave: burst-read weight memory with a side preload write port.
// Optional `define WMEM_RANGE_CHECK_EN flags beats beyond DEPTH on rerr instead of wrapping.
module weight_mem_slave #(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int BURST = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arvalid,
   output logic                     arready,
   input  logic [AW-1:0]            araddr,
   input  logic [3:0]               arburst,
   output logic                     rvalid,
   output logic [DW-1:0]            rdata,
   output logic                     rlast,
   input  logic                     mem_we,
   input  logic [$clog2(DEPTH)-1:0] mem_waddr,
   input  logic [DW-1:0]            mem_wdata
`ifdef WMEM_RANGE_CHECK_EN
   ,
   output logic                     rerr
`endif
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   // Handshake: a request transfers on a rising edge where arvalid && arready;
   // beats then stream on rvalid for BURST cycles and the initiator never stalls them.
   state_t           r_state;
   state_t           w_next;
   logic             r_live;
   logic [CW-1:0]    r_cnt;
   logic [AW-1:0]    r_base;
   logic             r_fixed;
   logic [DW-1:0]    r_mem_q;
   logic [DW-1:0]    r_mem [DEPTH];
   logic             w_accept;
   logic [AW-1:0]    w_base;
   logic [AW:0]      w_off;
   logic [AW:0]      w_addr_full;
   logic [IW-1:0]    w_rd_idx;

   assign w_accept = arvalid && arready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_live  <= 1'b0;
         r_cnt   <= '0;
         r_base  <= '0;
         r_fixed <= 1'b0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
         if (w_accept) begin
            r_base  <= araddr;
            r_fixed <= (arburst == 4'h0);
            r_cnt   <= '0;
         end else if (r_state == S_BURST) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_BURST;
         S_BURST: if (r_cnt == LAST_BEAT) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Address issued this cycle is the one for the beat shown next cycle:
   // the accept cycle issues beat 0 straight from araddr.
   always_comb begin
      w_base = araddr;
      w_off  = '0;
      if (r_state == S_BURST) begin
         w_base = r_base;
         if (!r_fixed) w_off = (AW+1)'(r_cnt) + (AW+1)'(1);
      end
      w_addr_full = {1'b0, w_base} + w_off;
      w_rd_idx    = w_addr_full[IW-1:0];
   end

   // Nonblocking read and write in one block give read-before-write on collision.
   always_ff @(posedge clk) begin
      if (mem_we) r_mem[mem_waddr] <= mem_wdata;
      r_mem_q <= r_mem[w_rd_idx];
   end

`ifdef WMEM_RANGE_CHECK_EN
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   logic r_err;

   always_ff @(posedge clk) begin
      r_err <= (w_addr_full >= DEPTH_W);
   end

   always_comb begin
      arready = (r_state == S_IDLE) && r_live;
      rvalid  = (r_state == S_BURST);
      rlast   = rvalid && (r_cnt == LAST_BEAT);
      rerr    = rvalid && r_err;
      rdata   = (rvalid && !r_err) ? r_mem_q : '0;
   end
`else
   logic w_unused;
   assign w_unused = ^w_addr_full[AW:IW];

   always_comb begin
      arready = (r_state == S_IDLE) && r_live;
      rvalid  = (r_state == S_BURST);
      rlast   = rvalid && (r_cnt == LAST_BEAT);
      rdata   = rvalid ? r_mem_q : '0;
   end
`endif

endmodule
